// File: rtl/proc_bus_pkg.sv
// Shared constants for the proc2 bus responder: region codes, timer register
// indices and the registered read-select encoding.
package proc_bus_pkg;

  localparam logic [3:0] REG_RAM = 4'h0;
  localparam logic [3:0] REG_LED = 4'h1;
  localparam logic [3:0] REG_SW  = 4'h3;
  localparam logic [3:0] REG_TMR = 4'h4;

  localparam logic [1:0] TMR_COUNT  = 2'd0;
  localparam logic [1:0] TMR_STATUS = 2'd1;
  localparam logic [1:0] TMR_CTRL   = 2'd2;

  typedef enum logic [2:0] {
    SelNone,
    SelRam,
    SelLed,
    SelSw,
    SelTmr
  } sel_e;

  function automatic sel_e decode_region(input logic [3:0] region);
    sel_e sel;
    case (region)
      REG_RAM: sel = SelRam;
      REG_LED: sel = SelLed;
      REG_SW:  sel = SelSw;
      REG_TMR: sel = SelTmr;
      default: sel = SelNone;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/bus_timer.sv
// 16-bit reload down-counter with a sticky expired flag that is cleared by a
// STATUS read; a new expiry on the clearing edge takes priority.
module bus_timer (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_wr_count,
  input  logic        i_wr_ctrl,
  input  logic [15:0] i_wdata,
  input  logic        i_clr_expired,
  output logic [15:0] o_count,
  output logic        o_enable,
  output logic        o_expired
);

  logic [15:0] r_count, r_reload;
  logic        r_enable, r_expired;
  logic [15:0] w_count_d, w_reload_d;
  logic        w_enable_d, w_expired_d, w_expire;

  always_comb begin
    w_expire    = r_enable && (r_count == 16'd1);
    w_count_d   = r_count;
    w_reload_d  = r_reload;
    w_enable_d  = r_enable;
    w_expired_d = r_expired;
    // A COUNT write overrides both reload and decrement on the same edge.
    if (i_wr_count) begin
      w_count_d  = i_wdata;
      w_reload_d = i_wdata;
    end else if (w_expire) begin
      w_count_d = r_reload;
    end else if (r_enable && (r_count != 16'd0)) begin
      w_count_d = r_count - 16'd1;
    end
    if (i_wr_ctrl) begin
      w_enable_d = i_wdata[0];
    end
    if (w_expire) begin
      w_expired_d = 1'b1;
    end else if (i_clr_expired) begin
      w_expired_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count   <= 16'd0;
      r_reload  <= 16'd0;
      r_enable  <= 1'b0;
      r_expired <= 1'b0;
    end else begin
      r_count   <= w_count_d;
      r_reload  <= w_reload_d;
      r_enable  <= w_enable_d;
      r_expired <= w_expired_d;
    end
  end

  assign o_count   = r_count;
  assign o_enable  = r_enable;
  assign o_expired = r_expired;

endmodule

// File: rtl/proc_bus_responder.sv
// proc2 data-bus responder: decodes RAM, LED, switch and timer regions and
// returns read data on o_din one clock after the address.
module proc_bus_responder
  import proc_bus_pkg::*;
#(
  parameter int unsigned RAM_AW = 8,
  parameter int unsigned LED_W  = 10,
  parameter int unsigned SW_W   = 10
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [15:0]      i_addr,
  input  logic [15:0]      i_dout,
  input  logic             i_w,
  output logic [15:0]      o_din,
  input  logic [SW_W-1:0]  i_sw,
  output logic [LED_W-1:0] o_ledr,
  output logic             o_irq
);

  localparam int unsigned RAM_DEPTH = 2 ** RAM_AW;

  sel_e              w_sel;
  logic [1:0]        w_tsub;
  logic [RAM_AW-1:0] w_ram_idx;
  logic              w_ram_we, w_led_we, w_tmr_wr_count, w_tmr_wr_ctrl, w_tmr_clr;
  logic [15:0]       w_tmr_count, w_tmr_rdata;
  logic              w_tmr_enable, w_tmr_expired;
  logic              w_unused;

  sel_e              r_sel;
  logic [15:0]       r_tmr_q;
  logic [15:0]       r_ram_q;
  logic [LED_W-1:0]  r_ledr;
  logic [SW_W-1:0]   r_sw_meta, r_sw_sync;
  logic [15:0]       r_mem [RAM_DEPTH];

  assign w_sel     = decode_region(i_addr[15:12]);
  assign w_tsub    = i_addr[1:0];
  assign w_ram_idx = i_addr[RAM_AW-1:0];
  assign w_unused  = ^i_addr[11:RAM_AW];

  assign w_ram_we       = i_w && (w_sel == SelRam);
  assign w_led_we       = i_w && (w_sel == SelLed);
  assign w_tmr_wr_count = i_w && (w_sel == SelTmr) && (w_tsub == TMR_COUNT);
  assign w_tmr_wr_ctrl  = i_w && (w_sel == SelTmr) && (w_tsub == TMR_CTRL);
  // Any access to STATUS is a read, so it clears regardless of W.
  assign w_tmr_clr      = (w_sel == SelTmr) && (w_tsub == TMR_STATUS);

  bus_timer u_timer (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_wr_count    (w_tmr_wr_count),
    .i_wr_ctrl     (w_tmr_wr_ctrl),
    .i_wdata       (i_dout),
    .i_clr_expired (w_tmr_clr),
    .o_count       (w_tmr_count),
    .o_enable      (w_tmr_enable),
    .o_expired     (w_tmr_expired)
  );

  always_comb begin
    w_tmr_rdata = 16'h0000;
    case (w_tsub)
      TMR_COUNT:  w_tmr_rdata = w_tmr_count;
      TMR_STATUS: w_tmr_rdata = {15'd0, w_tmr_expired};
      TMR_CTRL:   w_tmr_rdata = {15'd0, w_tmr_enable};
      default:    w_tmr_rdata = 16'h0000;
    endcase
  end

  // Read-first single-port RAM; contents are deliberately not reset.
  always_ff @(posedge i_clk) begin
    if (w_ram_we) begin
      r_mem[w_ram_idx] <= i_dout;
    end
    r_ram_q <= r_mem[w_ram_idx];
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sel     <= SelNone;
      r_tmr_q   <= 16'h0000;
      r_ledr    <= '0;
      r_sw_meta <= '0;
      r_sw_sync <= '0;
    end else begin
      r_sel     <= w_sel;
      r_tmr_q   <= w_tmr_rdata;
      r_sw_meta <= i_sw;
      r_sw_sync <= r_sw_meta;
      if (w_led_we) begin
        r_ledr <= i_dout[LED_W-1:0];
      end
    end
  end

  always_comb begin
    o_din = 16'h0000;
    case (r_sel)
      SelRam:  o_din = r_ram_q;
      SelLed:  o_din = 16'(r_ledr);
      SelSw:   o_din = 16'(r_sw_sync);
      SelTmr:  o_din = r_tmr_q;
      default: o_din = 16'h0000;
    endcase
  end

  assign o_ledr = r_ledr;
  assign o_irq  = w_tmr_expired;

endmodule

// File: tb/tb_proc_bus_responder.sv
// Self-checking bench for proc_bus_responder: expected read data is queued when
// a read is driven and compared when o_din presents it one clock later.
module tb_proc_bus_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] addr, dout, din;
  logic        w;
  logic [9:0]  sw, ledr;
  logic        irq;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [15:0] exp;
    string       name;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [15:0] a;
    logic [15:0] d;
    logic        wr;
    logic        cd;
    logic [15:0] ed;
    logic        ci;
    logic        ei;
  } step_t;
  step_t steps[$];

  always #5 clk = ~clk;

  proc_bus_responder dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_addr  (addr),
    .i_dout  (dout),
    .i_w     (w),
    .o_din   (din),
    .i_sw    (sw),
    .o_ledr  (ledr),
    .o_irq   (irq)
  );

  task automatic drive(input logic [15:0] a, input logic [15:0] d, input logic wr);
    addr = a;
    dout = d;
    w    = wr;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] e, input string n);
    exp_t x;
    x.exp  = e;
    x.name = n;
    sb.push_back(x);
  endtask

  task automatic add(input logic [15:0] a, input logic [15:0] d, input logic wr,
                     input logic cd, input logic [15:0] ed, input logic ci, input logic ei);
    step_t s;
    s.a = a; s.d = d; s.wr = wr; s.cd = cd; s.ed = ed; s.ci = ci; s.ei = ei;
    steps.push_back(s);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    sw    = '0;
    drive(16'h1000, 16'h03FF, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      checks += 3;
      if (ledr !== 10'h000) begin failures++; $display("FAIL reset_ledr ledr=%h exp=000", ledr); end
      if (din !== 16'h0000) begin failures++; $display("FAIL reset_din din=%h exp=0000", din); end
      if (irq !== 1'b0) begin failures++; $display("FAIL reset_irq irq=%b exp=0", irq); end
    end
    rst_n = 1'b1;
    drive(16'h7000, 16'h0000, 1'b0);
    tick();
  endtask

  task automatic test_ram;
    exp_t e;
    logic [15:0] ra[4];
    logic [15:0] rd[4];
    ra[0] = 16'h0005; rd[0] = 16'hBEEF;
    ra[1] = 16'h00FF; rd[1] = 16'hA5A5;
    ra[2] = 16'h0000; rd[2] = 16'h5A5A;
    ra[3] = 16'h0080; rd[3] = 16'h0F0F;
    for (int i = 0; i < 4; i++) begin
      drive(ra[i], rd[i], 1'b1);
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      drive(ra[i], 16'hFFFF, 1'b0);
      push(rd[i], $sformatf("ram_rd_%0h", ra[i]));
      tick();
      e = sb.pop_front();
      checks++;
      if (din !== e.exp) begin failures++; $display("FAIL %s din=%h exp=%h", e.name, din, e.exp); end
    end
    drive(16'h0006, 16'h1234, 1'b1);
    tick();
    drive(16'h0006, 16'h5678, 1'b1);
    push(16'h1234, "ram_read_first_old");
    tick();
    e = sb.pop_front();
    checks++;
    if (din !== e.exp) begin failures++; $display("FAIL %s din=%h exp=%h", e.name, din, e.exp); end
    drive(16'h0006, 16'h0000, 1'b0);
    push(16'h5678, "ram_read_first_new");
    tick();
    e = sb.pop_front();
    checks++;
    if (din !== e.exp) begin failures++; $display("FAIL %s din=%h exp=%h", e.name, din, e.exp); end
  endtask

  task automatic test_io;
    exp_t e;
    drive(16'h1000, 16'h02A5, 1'b1);
    tick();
    checks++;
    if (ledr !== 10'h2A5) begin failures++; $display("FAIL led_write ledr=%h exp=2a5", ledr); end
    drive(16'h1000, 16'h0000, 1'b0);
    push(16'h02A5, "led_read");
    tick();
    e = sb.pop_front();
    checks++;
    if (din !== e.exp) begin failures++; $display("FAIL %s din=%h exp=%h", e.name, din, e.exp); end
    drive(16'h1FFF, 16'hFFFF, 1'b1);
    tick();
    checks++;
    if (ledr !== 10'h3FF) begin failures++; $display("FAIL led_trunc ledr=%h exp=3ff", ledr); end
    sw = 10'h155;
    drive(16'h3000, 16'h0000, 1'b0);
    tick();
    tick();
    push(16'h0155, "sw_read");
    tick();
    e = sb.pop_front();
    checks++;
    if (din !== e.exp) begin failures++; $display("FAIL %s din=%h exp=%h", e.name, din, e.exp); end
    drive(16'h3000, 16'hFFFF, 1'b1);
    push(16'h0155, "sw_write_ignored");
    tick();
    e = sb.pop_front();
    checks += 2;
    if (din !== e.exp) begin failures++; $display("FAIL %s din=%h exp=%h", e.name, din, e.exp); end
    if (ledr !== 10'h3FF) begin failures++; $display("FAIL sw_write_led ledr=%h exp=3ff", ledr); end
    drive(16'h7000, 16'hFFFF, 1'b1);
    push(16'h0000, "unmapped_7000");
    tick();
    e = sb.pop_front();
    checks += 2;
    if (din !== e.exp) begin failures++; $display("FAIL %s din=%h exp=%h", e.name, din, e.exp); end
    if (ledr !== 10'h3FF) begin failures++; $display("FAIL unmapped_led ledr=%h exp=3ff", ledr); end
    drive(16'h2000, 16'h0000, 1'b0);
    push(16'h0000, "unmapped_2000");
    tick();
    e = sb.pop_front();
    checks++;
    if (din !== e.exp) begin failures++; $display("FAIL %s din=%h exp=%h", e.name, din, e.exp); end
    drive(16'h0000, 16'h0000, 1'b0);
    push(16'h5A5A, "ram_after_unmapped_wr");
    tick();
    e = sb.pop_front();
    checks++;
    if (din !== e.exp) begin failures++; $display("FAIL %s din=%h exp=%h", e.name, din, e.exp); end
  endtask

  task automatic test_timer;
    exp_t e;
    steps.delete();
    add(16'h4000, 16'd3, 1'b1, 1'b0, 16'd0, 1'b0, 1'b0);
    add(16'h4002, 16'd1, 1'b1, 1'b0, 16'd0, 1'b1, 1'b0);
    add(16'h4000, 16'd0, 1'b0, 1'b1, 16'd3, 1'b1, 1'b0);
    add(16'h4000, 16'd0, 1'b0, 1'b1, 16'd2, 1'b1, 1'b0);
    add(16'h4000, 16'd0, 1'b0, 1'b1, 16'd1, 1'b1, 1'b1);
    add(16'h4000, 16'd0, 1'b0, 1'b1, 16'd3, 1'b1, 1'b1);
    add(16'h4000, 16'd0, 1'b0, 1'b1, 16'd2, 1'b1, 1'b1);
    add(16'h4001, 16'd0, 1'b0, 1'b1, 16'd1, 1'b1, 1'b1);
    add(16'h4001, 16'd0, 1'b0, 1'b1, 16'd1, 1'b1, 1'b0);
    add(16'h4000, 16'd0, 1'b0, 1'b1, 16'd2, 1'b1, 1'b0);
    add(16'h4001, 16'd0, 1'b0, 1'b1, 16'd0, 1'b1, 1'b1);
    add(16'h4000, 16'd0, 1'b0, 1'b1, 16'd3, 1'b1, 1'b1);
    add(16'h4000, 16'd0, 1'b0, 1'b1, 16'd2, 1'b1, 1'b1);
    add(16'h4000, 16'd7, 1'b1, 1'b1, 16'd1, 1'b1, 1'b1);
    add(16'h4000, 16'd0, 1'b0, 1'b1, 16'd7, 1'b1, 1'b1);
    add(16'h4002, 16'd0, 1'b1, 1'b1, 16'd1, 1'b1, 1'b1);
    add(16'h4000, 16'd0, 1'b1, 1'b1, 16'd5, 1'b1, 1'b1);
    add(16'h4001, 16'd0, 1'b0, 1'b1, 16'd1, 1'b1, 1'b0);
    add(16'h4002, 16'd1, 1'b1, 1'b1, 16'd0, 1'b1, 1'b0);
    add(16'h4000, 16'd0, 1'b0, 1'b1, 16'd0, 1'b1, 1'b0);
    add(16'h4000, 16'd0, 1'b0, 1'b1, 16'd0, 1'b1, 1'b0);
    add(16'h4000, 16'd0, 1'b0, 1'b1, 16'd0, 1'b1, 1'b0);
    add(16'h4001, 16'd0, 1'b0, 1'b1, 16'd0, 1'b1, 1'b0);
    foreach (steps[i]) begin
      drive(steps[i].a, steps[i].d, steps[i].wr);
      if (steps[i].cd) push(steps[i].ed, $sformatf("tmr_din_step%0d", i));
      tick();
      if (steps[i].cd) begin
        e = sb.pop_front();
        checks++;
        if (din !== e.exp) begin failures++; $display("FAIL %s din=%h exp=%h", e.name, din, e.exp); end
      end
      if (steps[i].ci) begin
        checks++;
        if (irq !== steps[i].ei) begin
          failures++;
          $display("FAIL tmr_irq_step%0d irq=%b exp=%b", i, irq, steps[i].ei);
        end
      end
    end
  endtask

  task automatic test_midop_reset;
    exp_t e;
    drive(16'h4000, 16'd2, 1'b1);
    tick();
    drive(16'h4002, 16'd1, 1'b1);
    tick();
    drive(16'h1000, 16'h00AB, 1'b1);
    tick();
    drive(16'h1000, 16'h0000, 1'b0);
    push(16'h00AB, "midop_led_before");
    tick();
    e = sb.pop_front();
    checks += 2;
    if (din !== e.exp) begin failures++; $display("FAIL %s din=%h exp=%h", e.name, din, e.exp); end
    if (irq !== 1'b1) begin failures++; $display("FAIL midop_irq_before irq=%b exp=1", irq); end
    #2;
    rst_n = 1'b0;
    #1;
    checks += 3;
    if (ledr !== 10'h000) begin failures++; $display("FAIL midop_ledr ledr=%h exp=000", ledr); end
    if (irq !== 1'b0) begin failures++; $display("FAIL midop_irq irq=%b exp=0", irq); end
    if (din !== 16'h0000) begin failures++; $display("FAIL midop_din din=%h exp=0000", din); end
    tick();
    rst_n = 1'b1;
    drive(16'h0005, 16'h0000, 1'b0);
    push(16'hBEEF, "midop_ram_kept");
    #1;
    checks++;
    if (din !== 16'h0000) begin failures++; $display("FAIL midop_first_latency din=%h exp=0000", din); end
    tick();
    e = sb.pop_front();
    checks++;
    if (din !== e.exp) begin failures++; $display("FAIL %s din=%h exp=%h", e.name, din, e.exp); end
    drive(16'h4000, 16'h0000, 1'b0);
    push(16'h0000, "midop_count_cleared");
    tick();
    e = sb.pop_front();
    checks++;
    if (din !== e.exp) begin failures++; $display("FAIL %s din=%h exp=%h", e.name, din, e.exp); end
    drive(16'h4002, 16'h0000, 1'b0);
    push(16'h0000, "midop_enable_cleared");
    tick();
    e = sb.pop_front();
    tick();
    tick();
    checks += 2;
    if (din !== e.exp) begin failures++; $display("FAIL %s din=%h exp=%h", e.name, din, e.exp); end
    if (irq !== 1'b0) begin failures++; $display("FAIL midop_irq_after irq=%b exp=0", irq); end
  endtask

  initial begin
    test_reset();
    test_ram();
    test_io();
    test_timer();
    test_midop_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
